// File: rtl/memory_responder.sv
// Memory target for the core: one word RAM shared by fetch and data ports,
// plus an MMIO block holding a console TX FIFO, a status word and a cycle counter.
module memory_responder #(
    parameter int              XLEN       = 32,
    parameter int              MEM_WORDS  = 1024,
    parameter int              FIFO_DEPTH = 8,
    parameter logic [XLEN-1:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instr_addr,
    output logic [31:0]     instr_in,
    input  logic            data_we,
    input  logic [XLEN-1:0] data_addr,
    input  logic [XLEN-1:0] data_out,
    output logic [XLEN-1:0] data_in,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            bus_err
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_q  [MEM_WORDS];
    logic [7:0]       fifo_q [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [XLEN-1:0]  cycle_q, cycle_d;
    logic             bus_err_q, bus_err_d;

    logic             instr_ram_hit, data_ram_hit, mmio_hit;
    logic             tx_hit, status_hit, cycle_hit, data_unmapped;
    logic [IDX_W-1:0] instr_idx, data_idx;
    logic             fifo_empty, fifo_full, push_req, push_ok, pop;
    logic [XLEN-1:0]  status_word;
    logic             unused_addr_bits;

    // Word-granular decode; the low two address bits never matter.
    assign instr_ram_hit    = (instr_addr[XLEN-1:IDX_W+2] == '0);
    assign data_ram_hit     = (data_addr[XLEN-1:IDX_W+2] == '0);
    assign instr_idx        = instr_addr[IDX_W+1:2];
    assign data_idx         = data_addr[IDX_W+1:2];
    assign mmio_hit         = (data_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4]);
    assign tx_hit           = mmio_hit && (data_addr[3:2] == 2'd0);
    assign status_hit       = mmio_hit && (data_addr[3:2] == 2'd1);
    assign cycle_hit        = mmio_hit && (data_addr[3:2] == 2'd2);
    assign data_unmapped    = !data_ram_hit && !(mmio_hit && data_addr[3:2] != 2'd3);
    assign unused_addr_bits = ^{instr_addr[1:0], data_addr[1:0]};

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign status_word = XLEN'({count_q, 5'b0, ovf_q, fifo_empty, fifo_full});

    assign instr_in = instr_ram_hit ? mem_q[instr_idx][31:0] : 32'h0000_0013;
    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign bus_err  = bus_err_q;

    always_comb begin
        data_in = '0;
        if (data_ram_hit) begin
            data_in = mem_q[data_idx];
        end else if (status_hit) begin
            data_in = status_word;
        end else if (cycle_hit) begin
            data_in = cycle_q;
        end
    end

    always_comb begin
        push_req  = data_we && tx_hit;
        pop       = !fifo_empty && tx_ready;
        // A full FIFO still takes a byte when the head leaves in the same cycle.
        push_ok   = push_req && (!fifo_full || pop);
        rd_ptr_d  = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        ovf_d     = ovf_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (data_we && status_hit && data_out[2]) begin
            ovf_d = 1'b0;
        end
        cycle_d   = (data_we && cycle_hit) ? data_out : cycle_q + XLEN'(1);
        bus_err_d = bus_err_q || !instr_ram_hit || (data_we && data_unmapped);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cycle_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            cycle_q   <= cycle_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Storage arrays have no reset; RAM survives reset by design.
    always_ff @(posedge clk) begin
        if (rst_n && data_we && data_ram_hit) begin
            mem_q[data_idx] <= data_out;
        end
        if (rst_n && push_ok) begin
            fifo_q[wr_ptr_q] <= data_out[7:0];
        end
    end

endmodule
